// File: rtl/regfile_scoreboard_if.sv
// Issue / write-back / flush bundle between the issue stage and the
// register-file scoreboard. The master drives instructions and write-backs;
// the slave (scoreboard) returns the stall flag, operand data and status.
interface regfile_scoreboard_if #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int NRD     = 2,
  parameter int MAXPEND = 3
);
  localparam int AW = $clog2(NREG);
  localparam int IW = $clog2(NREG*MAXPEND+1);

  logic                issue_valid;
  logic [NRD*AW-1:0]   issue_rs;
  logic [NRD-1:0]      issue_rs_used;
  logic [AW-1:0]       issue_rd;
  logic                issue_we;
  logic                issue_ready;
  logic [NRD*XLEN-1:0] rdata;
  logic                wb_we;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                flush;
  logic [IW-1:0]       inflight;
  logic                wb_err;

  modport master (
    output issue_valid, issue_rs, issue_rs_used, issue_rd, issue_we,
    output wb_we, wb_addr, wb_data, flush,
    input  issue_ready, rdata, inflight, wb_err
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rs_used, issue_rd, issue_we,
    input  wb_we, wb_addr, wb_data, flush,
    output issue_ready, rdata, inflight, wb_err
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register outstanding-write counters for the issue
// stage. Operand reads are combinational with same-cycle write-back bypass;
// issue_ready drops on RAW hazards, counter saturation, or flush.
// Register 0 is hardwired to zero and never tracked.
module regfile_scoreboard #(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int NRD     = 2,
  parameter int MAXPEND = 3
) (
  input logic                clk,
  input logic                nrst,
  regfile_scoreboard_if.slave bus
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(MAXPEND+1);
  localparam int IW = $clog2(NREG*MAXPEND+1);

  logic [XLEN-1:0] regs_q    [NREG];
  logic [CW-1:0]   pending_q [NREG];
  logic [CW-1:0]   pending_d [NREG];
  logic [IW-1:0]   inflight_q, inflight_d;
  logic            wb_err_q, wb_err_d;

  logic [NRD-1:0]      raw_hz;
  logic                sat_hz;
  logic                ready;
  logic                fire;
  logic                inc;
  logic                dec;
  logic [NRD*XLEN-1:0] rdata_c;

  // Operand read with write-back bypass and per-port RAW hazard detection.
  // A consumer may proceed when the write-back in this cycle is the last one
  // outstanding for its source, since the bypass hands it the final value.
  always_comb begin
    logic [AW-1:0] rs;
    rs      = '0;
    rdata_c = '0;
    raw_hz  = '0;
    for (int i = 0; i < NRD; i++) begin
      rs = bus.issue_rs[i*AW +: AW];
      if (rs == '0)
        rdata_c[i*XLEN +: XLEN] = '0;
      else if (bus.wb_we && bus.wb_addr == rs)
        rdata_c[i*XLEN +: XLEN] = bus.wb_data;
      else
        rdata_c[i*XLEN +: XLEN] = regs_q[rs];
      raw_hz[i] = bus.issue_rs_used[i] && (rs != '0) && (pending_q[rs] != '0)
                  && !(bus.wb_we && bus.wb_addr == rs && pending_q[rs] == CW'(1));
    end
  end

  // Saturation stall, ready and the increment/decrement strobes.
  // A write-back to rd in the same cycle frees a slot, so a full counter
  // does not stall then (inc and dec cancel and the count stays at max).
  always_comb begin
    sat_hz = bus.issue_we && (bus.issue_rd != '0)
             && (pending_q[bus.issue_rd] == CW'(MAXPEND))
             && !(bus.wb_we && bus.wb_addr == bus.issue_rd);
    ready  = !bus.flush && (raw_hz == '0) && !sat_hz;
    fire   = bus.issue_valid && ready;
    inc    = fire && bus.issue_we && (bus.issue_rd != '0);
    dec    = bus.wb_we && (bus.wb_addr != '0) && (pending_q[bus.wb_addr] != '0);
  end

  // Next-state pending counters, their total, and the sticky error flag.
  always_comb begin
    logic inc_r;
    logic dec_r;
    inc_r      = 1'b0;
    dec_r      = 1'b0;
    inflight_d = '0;
    for (int r = 0; r < NREG; r++) begin
      pending_d[r] = pending_q[r];
      if (r != 0) begin
        inc_r = inc && (bus.issue_rd == AW'(r));
        dec_r = dec && (bus.wb_addr == AW'(r));
        if (inc_r && !dec_r)
          pending_d[r] = pending_q[r] + CW'(1);
        else if (dec_r && !inc_r)
          pending_d[r] = pending_q[r] - CW'(1);
      end else begin
        pending_d[r] = '0;
      end
      if (bus.flush)
        pending_d[r] = '0;
      inflight_d = inflight_d + IW'(pending_d[r]);
    end
    wb_err_d = wb_err_q
               || (bus.wb_we && (bus.wb_addr != '0) && (pending_q[bus.wb_addr] == '0));
  end

  // State registers; write-back to the array happens even during flush.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r]    <= '0;
        pending_q[r] <= '0;
      end
      inflight_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      if (bus.wb_we && bus.wb_addr != '0)
        regs_q[bus.wb_addr] <= bus.wb_data;
      for (int r = 0; r < NREG; r++)
        pending_q[r] <= pending_d[r];
      inflight_q <= inflight_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign bus.issue_ready = ready;
  assign bus.rdata       = rdata_c;
  assign bus.inflight    = inflight_q;
  assign bus.wb_err      = wb_err_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Table-driven bench for regfile_scoreboard. Each vector drives one cycle of
// inputs; its expectations go to a queue and are popped and compared when
// the DUT answers (combinational outputs mid-cycle, registered after the edge).
module tb_regfile_scoreboard;
  localparam int XLEN = 32, NREG = 32, NRD = 2, MAXPEND = 3;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .MAXPEND(MAXPEND)) bus ();

  regfile_scoreboard #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .MAXPEND(MAXPEND)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  typedef struct {
    logic        iv;
    logic [4:0]  rs0, rs1;
    logic [1:0]  used;
    logic [4:0]  rd;
    logic        we;
    logic        wbwe;
    logic [4:0]  wbaddr;
    logic [31:0] wbdata;
    logic        fl;
    logic        e_ready;
    logic [31:0] e_r0, e_r1;
    logic [7:0]  e_infl;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int total = 0;
  int bad = 0;

  function automatic vec_t mk(logic iv, logic [4:0] rs0, logic [4:0] rs1, logic [1:0] used,
                              logic [4:0] rd, logic we, logic wbwe, logic [4:0] wbaddr,
                              logic [31:0] wbdata, logic fl, logic e_ready,
                              logic [31:0] e_r0, logic [31:0] e_r1, logic [7:0] e_infl,
                              logic e_err);
    vec_t v;
    v.iv = iv; v.rs0 = rs0; v.rs1 = rs1; v.used = used; v.rd = rd; v.we = we;
    v.wbwe = wbwe; v.wbaddr = wbaddr; v.wbdata = wbdata; v.fl = fl;
    v.e_ready = e_ready; v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_infl = e_infl; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0; bus.issue_rs = '0; bus.issue_rs_used = '0;
    bus.issue_rd = '0; bus.issue_we = 1'b0; bus.wb_we = 1'b0;
    bus.wb_addr = '0; bus.wb_data = '0; bus.flush = 1'b0;
  endtask

  // Called at posedge+1: drive one vector, check combinational outputs at the
  // falling edge, then registered outputs just after the next rising edge.
  task automatic step(int idx, vec_t v);
    vec_t e;
    bus.issue_valid   = v.iv;
    bus.issue_rs      = {v.rs1, v.rs0};
    bus.issue_rs_used = v.used;
    bus.issue_rd      = v.rd;
    bus.issue_we      = v.we;
    bus.wb_we         = v.wbwe;
    bus.wb_addr       = v.wbaddr;
    bus.wb_data       = v.wbdata;
    bus.flush         = v.fl;
    sb.push_back(v);
    @(negedge clk);
    e = sb.pop_front();
    chk($sformatf("v%0d ready", idx), 32'(bus.issue_ready), 32'(e.e_ready));
    chk($sformatf("v%0d rdata0", idx), bus.rdata[31:0], e.e_r0);
    chk($sformatf("v%0d rdata1", idx), bus.rdata[63:32], e.e_r1);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d inflight", idx), 32'(bus.inflight), 32'(e.e_infl));
    chk($sformatf("v%0d wb_err", idx), 32'(bus.wb_err), 32'(e.e_err));
  endtask

  initial begin
    //            iv rs0 rs1 used rd we wbwe wa wdata         fl | rdy r0            r1            infl err
    // reset state / reads of x5 and x0
    vecs.push_back(mk(0, 5, 0, 2'b00, 0, 0, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0,        0, 0));
    // RAW stall on x3, released by the final write-back with bypass
    vecs.push_back(mk(1, 0, 0, 2'b00, 3, 1, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(1, 3, 0, 2'b01, 0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(1, 3, 0, 2'b01, 0, 0, 1, 3, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 32'h0,        0, 0));
    vecs.push_back(mk(0, 3, 0, 2'b00, 0, 0, 0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 32'h0,        0, 0));
    // unused source does not stall
    vecs.push_back(mk(1, 0, 0, 2'b00, 3, 1, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(1, 3, 0, 2'b00, 0, 0, 0, 0, 32'h0,        0, 1, 32'hDEADBEEF, 32'h0,        1, 0));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 3, 32'h11111111, 0, 1, 32'h0,        32'h0,        0, 0));
    // pending==2: first write-back does not release, second does
    vecs.push_back(mk(1, 0, 0, 2'b00, 4, 1, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(1, 0, 0, 2'b00, 4, 1, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0,        2, 0));
    vecs.push_back(mk(1, 3, 4, 2'b10, 0, 0, 1, 4, 32'hAAAA0001, 0, 0, 32'h11111111, 32'hAAAA0001, 1, 0));
    vecs.push_back(mk(1, 3, 4, 2'b11, 0, 0, 1, 4, 32'hBBBB0002, 0, 1, 32'h11111111, 32'hBBBB0002, 0, 0));
    // saturation on x7
    vecs.push_back(mk(1, 0, 0, 2'b00, 7, 1, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(1, 0, 0, 2'b00, 7, 1, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0,        2, 0));
    vecs.push_back(mk(1, 0, 0, 2'b00, 7, 1, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0,        3, 0));
    vecs.push_back(mk(1, 0, 0, 2'b00, 7, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        3, 0));
    vecs.push_back(mk(1, 7, 0, 2'b00, 7, 1, 1, 7, 32'hC0C0C0C0, 0, 1, 32'hC0C0C0C0, 32'h0,        3, 0));
    vecs.push_back(mk(1, 0, 0, 2'b00, 7, 1, 0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        3, 0));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 7, 32'h70000001, 0, 1, 32'h0,        32'h0,        2, 0));
    vecs.push_back(mk(0, 0, 0, 2'b00, 0, 0, 1, 7, 32'h70000002, 0, 1, 32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(0, 7, 0, 2'b00, 0, 0, 1, 7, 32'h70000003, 0, 1, 32'h70000003, 32'h0,        0, 0));
    // x0: never tracked, never written, never flags an error
    vecs.push_back(mk(1, 0, 0, 2'b00, 0, 1, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(0, 0, 7, 2'b00, 0, 0, 1, 0, 32'h00001234, 0, 1, 32'h0,        32'h70000003, 0, 0));
    vecs.push_back(mk(0, 0, 0, 2'b11, 0, 0, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0,        0, 0));
    // flush with pending x1, x2; stale write-back afterwards flags wb_err
    vecs.push_back(mk(1, 0, 0, 2'b00, 1, 1, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0,        1, 0));
    vecs.push_back(mk(1, 0, 0, 2'b00, 2, 1, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0,        2, 0));
    vecs.push_back(mk(1, 0, 0, 2'b00, 5, 1, 0, 0, 32'h0,        1, 0, 32'h0,        32'h0,        0, 0));
    vecs.push_back(mk(1, 1, 0, 2'b01, 0, 0, 1, 1, 32'h00000055, 0, 1, 32'h00000055, 32'h0,        0, 1));
    vecs.push_back(mk(0, 1, 2, 2'b00, 0, 0, 0, 0, 32'h0,        0, 1, 32'h00000055, 32'h0,        0, 1));
    // build some state ahead of the mid-operation reset
    vecs.push_back(mk(1, 0, 0, 2'b00, 9, 1, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0,        1, 1));
    vecs.push_back(mk(1, 0, 0, 2'b00, 9, 1, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0,        2, 1));

    idle();
    nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++)
      step(i, vecs[i]);

    // Mid-operation reset: state clears immediately, without a clock edge.
    idle();
    bus.issue_rs = {5'd3, 5'd1};
    nrst = 1'b0;
    #1;
    chk("midrst inflight", 32'(bus.inflight), 32'd0);
    chk("midrst wb_err", 32'(bus.wb_err), 32'd0);
    chk("midrst rdata0", bus.rdata[31:0], 32'h0);
    chk("midrst rdata1", bus.rdata[63:32], 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    // x9 had two pending writes before reset; none survive, so no stall.
    bus.issue_valid = 1'b1;
    bus.issue_rs = {5'd0, 5'd9};
    bus.issue_rs_used = 2'b01;
    #1;
    chk("midrst ready", 32'(bus.issue_ready), 32'd1);
    bus.wb_we = 1'b1;
    bus.wb_addr = 5'd9;
    bus.wb_data = 32'h9999;
    @(posedge clk);
    #1;
    chk("midrst stale wb_err", 32'(bus.wb_err), 32'd1);
    chk("midrst stale inflight", 32'(bus.inflight), 32'd0);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
